// File: rtl/fb_packet_divide_bnd.sv
// Frame-buffer packet divider with address-boundary protection.
// Splits each read request (address, byte length, region tags) into packets
// that never exceed the latched packet length and never cross a
// 2^BOUNDARY_WD-byte boundary. Packets are handed downstream with a
// valid/ready handshake, the final packet of a request is marked, and the
// handshaken packets of a frame are counted.
module fb_packet_divide_bnd #(
    parameter int FRAME_BYTE_ADDR_WD = 27,
    parameter int PKT_LENGTH_WD      = 13,
    parameter int PKT_CNT_WD         = 16,
    parameter int BOUNDARY_WD        = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PKT_LENGTH_WD-1:0]      iv_pkt_length,
    input  logic                          i_fval,
    input  logic                          i_aval,
    input  logic                          i_info_flag,
    input  logic                          i_image_flag,
    input  logic                          i_statis_flag,
    input  logic [FRAME_BYTE_ADDR_WD-1:0] iv_rd_addr,
    input  logic [FRAME_BYTE_ADDR_WD-1:0] iv_rd_length,
    output logic                          o_ardy,
    input  logic                          i_ardy,
    output logic                          o_fval,
    output logic                          o_pval,
    output logic                          o_aval,
    output logic                          o_info_flag,
    output logic                          o_image_flag,
    output logic                          o_statis_flag,
    output logic [FRAME_BYTE_ADDR_WD-1:0] ov_rd_addr,
    output logic [FRAME_BYTE_ADDR_WD-1:0] ov_rd_length,
    output logic                          o_last_pkt,
    output logic [PKT_CNT_WD-1:0]         ov_pkt_cnt
);

    localparam int AW = FRAME_BYTE_ADDR_WD;
    localparam logic [AW-1:0] BND_BYTES = AW'(64'd1 << BOUNDARY_WD);
    localparam logic [PKT_CNT_WD-1:0] CNT_ONE = {{(PKT_CNT_WD-1){1'b0}}, 1'b1};
    localparam logic [PKT_CNT_WD-1:0] CNT_MAX = {PKT_CNT_WD{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;        // start of the packet being built/presented
    logic [AW-1:0]           remain_q, remain_d;    // bytes left including that packet
    logic [2:0]              req_flags_q, req_flags_d;
    logic [PKT_LENGTH_WD-1:0] plen_q, plen_d;
    logic                    fval_q, fval_d;
    logic                    end_pend_q, end_pend_d; // i_fval dropped while o_fval high
    logic                    aval_q, aval_d;
    logic                    pval_q, pval_d;
    logic [2:0]              out_flags_q, out_flags_d;
    logic [AW-1:0]           rd_addr_q, rd_addr_d;
    logic [AW-1:0]           rd_len_q, rd_len_d;
    logic                    last_q, last_d;
    logic [PKT_CNT_WD-1:0]   cnt_q, cnt_d;

    logic                    accept_s;
    logic                    hs_s;
    logic                    fall_s;
    logic                    rise_s;
    logic [AW-1:0]           cur_addr_s;
    logic [AW-1:0]           cur_rem_s;
    logic [AW-1:0]           room_s;
    logic [AW-1:0]           base_len_s;
    logic [AW-1:0]           plen_ext_s;
    logic [AW-1:0]           len_s;

    // Requests are only taken while idle inside an open, not-ending frame.
    assign o_ardy   = (state_q == IDLE) & i_fval & fval_q & ~end_pend_q;
    assign accept_s = o_ardy & i_aval;
    assign hs_s     = (state_q == ISSUE) & aval_q & i_ardy;
    assign fall_s   = (state_q == IDLE) & fval_q & (end_pend_q | ~i_fval);
    assign rise_s   = (state_q == IDLE) & ~fval_q & i_fval;

    // In ISSUE the next packet starts right after the one being handshaken,
    // so the same sizing logic serves both the first and follow-on packets.
    assign cur_addr_s = (state_q == ISSUE) ? (addr_q + rd_len_q) : addr_q;
    assign cur_rem_s  = (state_q == ISSUE) ? (remain_q - rd_len_q) : remain_q;
    assign room_s     = BND_BYTES - {{(AW-BOUNDARY_WD){1'b0}}, cur_addr_s[BOUNDARY_WD-1:0]};
    assign base_len_s = (cur_rem_s < room_s) ? cur_rem_s : room_s;
    assign plen_ext_s = {{(AW-PKT_LENGTH_WD){1'b0}}, plen_q};
    // A zero packet length means no length limit.
    assign len_s      = ((plen_q != {PKT_LENGTH_WD{1'b0}}) && (plen_ext_s < base_len_s))
                        ? plen_ext_s : base_len_s;

    // Next-state, packet datapath and frame bookkeeping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        req_flags_d = req_flags_q;
        plen_d      = plen_q;
        fval_d      = fval_q;
        end_pend_d  = end_pend_q;
        aval_d      = aval_q;
        pval_d      = pval_q;
        out_flags_d = out_flags_q;
        rd_addr_d   = rd_addr_q;
        rd_len_d    = rd_len_q;
        last_d      = last_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    addr_d      = iv_rd_addr;
                    remain_d    = iv_rd_length;
                    req_flags_d = {i_info_flag, i_image_flag, i_statis_flag};
                    state_d     = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (remain_q == {AW{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    addr_d      = cur_addr_s;
                    remain_d    = cur_rem_s;
                    rd_addr_d   = cur_addr_s;
                    rd_len_d    = len_s;
                    last_d      = (len_s == cur_rem_s);
                    out_flags_d = req_flags_q;
                    aval_d      = 1'b1;
                    pval_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (hs_s) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
                    if (last_q) begin
                        aval_d  = 1'b0;
                        pval_d  = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        addr_d    = cur_addr_s;
                        remain_d  = cur_rem_s;
                        rd_addr_d = cur_addr_s;
                        rd_len_d  = len_s;
                        last_d    = (len_s == cur_rem_s);
                        state_d   = ISSUE;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
                aval_d  = 1'b0;
                pval_d  = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        if (fall_s) begin
            fval_d     = 1'b0;
            end_pend_d = 1'b0;
        end else if (rise_s) begin
            fval_d = 1'b1;
            plen_d = iv_pkt_length;
            cnt_d  = {PKT_CNT_WD{1'b0}};
        end else if (fval_q & ~i_fval) begin
            end_pend_d = 1'b1;
        end else begin
            end_pend_d = end_pend_q;
        end
    end

    // State and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= {AW{1'b0}};
            remain_q    <= {AW{1'b0}};
            req_flags_q <= 3'b000;
            plen_q      <= {PKT_LENGTH_WD{1'b0}};
            fval_q      <= 1'b0;
            end_pend_q  <= 1'b0;
            aval_q      <= 1'b0;
            pval_q      <= 1'b0;
            out_flags_q <= 3'b000;
            rd_addr_q   <= {AW{1'b0}};
            rd_len_q    <= {AW{1'b0}};
            last_q      <= 1'b0;
            cnt_q       <= {PKT_CNT_WD{1'b0}};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            req_flags_q <= req_flags_d;
            plen_q      <= plen_d;
            fval_q      <= fval_d;
            end_pend_q  <= end_pend_d;
            aval_q      <= aval_d;
            pval_q      <= pval_d;
            out_flags_q <= out_flags_d;
            rd_addr_q   <= rd_addr_d;
            rd_len_q    <= rd_len_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_fval        = fval_q;
    assign o_pval        = pval_q;
    assign o_aval        = aval_q;
    assign o_info_flag   = out_flags_q[2];
    assign o_image_flag  = out_flags_q[1];
    assign o_statis_flag = out_flags_q[0];
    assign ov_rd_addr    = rd_addr_q;
    assign ov_rd_length  = rd_len_q;
    assign o_last_pkt    = last_q;
    assign ov_pkt_cnt    = cnt_q;

endmodule

// File: tb/tb_fb_packet_divide_bnd.sv
// Self-checking bench for fb_packet_divide_bnd: expected packets are queued
// when a request is driven and compared as each packet is handshaken.
module tb_fb_packet_divide_bnd;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] iv_pkt_length;
    logic        i_fval, i_aval, i_info_flag, i_image_flag, i_statis_flag;
    logic [26:0] iv_rd_addr, iv_rd_length;
    logic        o_ardy, i_ardy, o_fval, o_pval, o_aval;
    logic        o_info_flag, o_image_flag, o_statis_flag;
    logic [26:0] ov_rd_addr, ov_rd_length;
    logic        o_last_pkt;
    logic [15:0] ov_pkt_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [26:0] addr;
        logic [26:0] len;
        logic        last;
        logic [2:0]  flags;
    } pkt_t;

    typedef struct {
        logic [12:0] plen;
        logic [26:0] addr;
        logic [26:0] len;
        logic [2:0]  flags;
        int          npkts;
    } vec_t;

    pkt_t sb[$];
    vec_t vecs[8];

    fb_packet_divide_bnd dut (
        .clk(clk), .reset(reset), .iv_pkt_length(iv_pkt_length),
        .i_fval(i_fval), .i_aval(i_aval), .i_info_flag(i_info_flag),
        .i_image_flag(i_image_flag), .i_statis_flag(i_statis_flag),
        .iv_rd_addr(iv_rd_addr), .iv_rd_length(iv_rd_length), .o_ardy(o_ardy),
        .i_ardy(i_ardy), .o_fval(o_fval), .o_pval(o_pval), .o_aval(o_aval),
        .o_info_flag(o_info_flag), .o_image_flag(o_image_flag),
        .o_statis_flag(o_statis_flag), .ov_rd_addr(ov_rd_addr),
        .ov_rd_length(ov_rd_length), .o_last_pkt(o_last_pkt), .ov_pkt_cnt(ov_pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every handshaken packet must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && o_aval && i_ardy) begin
            if (sb.size() == 0) begin
                chk("unexpected_pkt", {5'd0, ov_rd_addr}, 32'hFFFF_FFFF);
            end else begin
                pkt_t e;
                e = sb.pop_front();
                chk("pkt_addr", {5'd0, ov_rd_addr}, {5'd0, e.addr});
                chk("pkt_len", {5'd0, ov_rd_length}, {5'd0, e.len});
                chk("pkt_last", {31'd0, o_last_pkt}, {31'd0, e.last});
                chk("pkt_flags", {29'd0, o_info_flag, o_image_flag, o_statis_flag}, {29'd0, e.flags});
            end
        end
    end

    task automatic push_pkt(input logic [26:0] a, input logic [26:0] l, input logic last, input logic [2:0] f);
        pkt_t p;
        p.addr = a; p.len = l; p.last = last; p.flags = f;
        sb.push_back(p);
    endtask

    // Reference splitter: min(remaining, bytes to next 4 KiB boundary, plen).
    task automatic push_model(input logic [12:0] plen, input logic [26:0] a, input logic [26:0] l, input logic [2:0] f);
        logic [26:0] ad, rem, room, ln;
        ad = a; rem = l;
        while (rem != 27'd0) begin
            room = 27'd4096 - {15'd0, ad[11:0]};
            ln = rem;
            if (room < ln) ln = room;
            if (plen != 13'd0 && {14'd0, plen} < ln) ln = {14'd0, plen};
            push_pkt(ad, ln, (ln == rem), f);
            ad = ad + ln;
            rem = rem - ln;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ardy"}, {31'd0, o_ardy}, 32'd0);
        chk({tag, "_fval"}, {31'd0, o_fval}, 32'd0);
        chk({tag, "_pval"}, {31'd0, o_pval}, 32'd0);
        chk({tag, "_aval"}, {31'd0, o_aval}, 32'd0);
        chk({tag, "_flags"}, {29'd0, o_info_flag, o_image_flag, o_statis_flag}, 32'd0);
        chk({tag, "_addr"}, {5'd0, ov_rd_addr}, 32'd0);
        chk({tag, "_len"}, {5'd0, ov_rd_length}, 32'd0);
        chk({tag, "_last"}, {31'd0, o_last_pkt}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, ov_pkt_cnt}, 32'd0);
    endtask

    task automatic start_frame(input logic [12:0] plen);
        int n;
        @(posedge clk); #1;
        iv_pkt_length = plen;
        i_fval = 1'b1;
        n = 0;
        @(negedge clk);
        while (!o_fval && n < 20) begin @(negedge clk); n++; end
        chk("fval_rise", {31'd0, o_fval}, 32'd1);
        chk("cnt_clear", {16'd0, ov_pkt_cnt}, 32'd0);
    endtask

    task automatic end_frame();
        int n;
        @(posedge clk); #1;
        i_fval = 1'b0;
        n = 0;
        @(negedge clk);
        while (o_fval && n < 200) begin @(negedge clk); n++; end
        chk("fval_fall", {31'd0, o_fval}, 32'd0);
    endtask

    task automatic send_req(input logic [26:0] a, input logic [26:0] l, input logic [2:0] f);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_ardy && n < 50) begin @(negedge clk); n++; end
        chk("ardy_wait", {31'd0, o_ardy}, 32'd1);
        i_aval = 1'b1;
        iv_rd_addr = a;
        iv_rd_length = l;
        {i_info_flag, i_image_flag, i_statis_flag} = f;
        @(posedge clk); #1;
        i_aval = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || o_pval) && n < 300) begin @(negedge clk); n++; end
        chk("sb_drained", sb.size(), 32'd0);
        chk("pval_low", {31'd0, o_pval}, 32'd0);
    endtask

    task automatic wait_aval();
        int n;
        n = 0;
        @(negedge clk);
        while (!o_aval && n < 20) begin @(negedge clk); n++; end
        chk("aval_wait", {31'd0, o_aval}, 32'd1);
    endtask

    // Hand the currently presented packet over with a one-cycle ready pulse.
    task automatic ready_pulse();
        @(posedge clk); #1; i_ardy = 1'b1;
        @(posedge clk); #1; i_ardy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{13'd256,  27'd0,         27'd1000, 3'b100, 4};
        vecs[1] = '{13'd256,  27'd4000,      27'd300,  3'b010, 2};
        vecs[2] = '{13'd100,  27'd4090,      27'd20,   3'b001, 2};
        vecs[3] = '{13'd4095, 27'd0,         27'd8192, 3'b100, 4};
        vecs[4] = '{13'd0,    27'd0,         27'd5000, 3'b010, 2};
        vecs[5] = '{13'd512,  27'h7FF_FF00,  27'd512,  3'b001, 2};
        vecs[6] = '{13'd8191, 27'd100,       27'd50,   3'b111, 1};
        vecs[7] = '{13'd1,    27'd10,        27'd3,    3'b110, 3};

        reset = 1'b1; iv_pkt_length = 13'd0; i_fval = 1'b0; i_aval = 1'b0;
        i_info_flag = 1'b0; i_image_flag = 1'b0; i_statis_flag = 1'b0;
        iv_rd_addr = 27'd0; iv_rd_length = 27'd0; i_ardy = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1; reset = 1'b0;

        // Basic split with latency check, then boundary split in same frame.
        start_frame(13'd256);
        push_pkt(27'd0, 27'd256, 1'b0, 3'b100);
        push_pkt(27'd256, 27'd256, 1'b0, 3'b100);
        push_pkt(27'd512, 27'd256, 1'b0, 3'b100);
        push_pkt(27'd768, 27'd232, 1'b1, 3'b100);
        send_req(27'd0, 27'd1000, 3'b100);
        @(negedge clk); chk("lat_calc_aval", {31'd0, o_aval}, 32'd0);
        @(negedge clk); chk("lat_issue_aval", {31'd0, o_aval}, 32'd1);
        wait_idle();
        chk("cnt_after_1000", {16'd0, ov_pkt_cnt}, 32'd4);
        push_pkt(27'd4000, 27'd96, 1'b0, 3'b010);
        push_pkt(27'd4096, 27'd204, 1'b1, 3'b010);
        send_req(27'd4000, 27'd300, 3'b010);
        wait_idle();
        chk("cnt_after_bnd", {16'd0, ov_pkt_cnt}, 32'd6);
        end_frame();

        // Table-driven requests, one frame each.
        for (int i = 0; i < 8; i++) begin
            start_frame(vecs[i].plen);
            push_model(vecs[i].plen, vecs[i].addr, vecs[i].len, vecs[i].flags);
            send_req(vecs[i].addr, vecs[i].len, vecs[i].flags);
            wait_idle();
            chk("vec_cnt", {16'd0, ov_pkt_cnt}, vecs[i].npkts);
            end_frame();
        end

        // Back-pressure on packet 2 of 4.
        start_frame(13'd256);
        @(posedge clk); #1; i_ardy = 1'b0;
        push_model(13'd256, 27'd0, 27'd1000, 3'b010);
        send_req(27'd0, 27'd1000, 3'b010);
        wait_aval();
        ready_pulse();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_aval", {31'd0, o_aval}, 32'd1);
            chk("stall_addr", {5'd0, ov_rd_addr}, 32'd256);
            chk("stall_len", {5'd0, ov_rd_length}, 32'd256);
            chk("stall_last", {31'd0, o_last_pkt}, 32'd0);
            chk("stall_cnt", {16'd0, ov_pkt_cnt}, 32'd1);
        end
        @(posedge clk); #1; i_ardy = 1'b1;
        wait_idle();
        chk("stall_cnt_end", {16'd0, ov_pkt_cnt}, 32'd4);

        // Frame end while packet 2 of 4 is pending.
        @(posedge clk); #1; i_ardy = 1'b0;
        push_model(13'd256, 27'd0, 27'd1000, 3'b001);
        send_req(27'd0, 27'd1000, 3'b001);
        wait_aval();
        ready_pulse();
        @(posedge clk); #1; i_fval = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("defer_fval", {31'd0, o_fval}, 32'd1);
            chk("defer_ardy", {31'd0, o_ardy}, 32'd0);
        end
        @(posedge clk); #1; i_ardy = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (o_pval && n < 50) begin
                chk("defer_fval_busy", {31'd0, o_fval}, 32'd1);
                @(negedge clk); n++;
            end
        end
        chk("defer_fval_idle", {31'd0, o_fval}, 32'd1);
        chk("defer_ardy_idle", {31'd0, o_ardy}, 32'd0);
        @(negedge clk);
        chk("defer_fval_fall", {31'd0, o_fval}, 32'd0);
        chk("defer_cnt", {16'd0, ov_pkt_cnt}, 32'd8);
        chk("defer_sb", sb.size(), 32'd0);

        // Asynchronous reset during ISSUE.
        start_frame(13'd256);
        @(posedge clk); #1; i_ardy = 1'b0;
        push_model(13'd256, 27'd0, 27'd1000, 3'b100);
        send_req(27'd0, 27'd1000, 3'b100);
        wait_aval();
        @(posedge clk); #1; reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        sb.delete();
        i_ardy = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        start_frame(13'd256);
        push_model(13'd256, 27'd100, 27'd600, 3'b010);
        send_req(27'd100, 27'd600, 3'b010);
        wait_idle();
        chk("post_reset_cnt", {16'd0, ov_pkt_cnt}, 32'd3);
        end_frame();

        // Zero-length request issues nothing; ready returns two cycles later.
        start_frame(13'd256);
        send_req(27'd64, 27'd0, 3'b100);
        @(negedge clk); chk("len0_ardy_calc", {31'd0, o_ardy}, 32'd0);
        @(negedge clk); chk("len0_ardy_back", {31'd0, o_ardy}, 32'd1);
        chk("len0_aval", {31'd0, o_aval}, 32'd0);
        repeat (3) @(negedge clk);
        chk("len0_aval_later", {31'd0, o_aval}, 32'd0);
        chk("len0_cnt", {16'd0, ov_pkt_cnt}, 32'd0);
        end_frame();

        // Unlimited packet length: only the boundary splits.
        start_frame(13'd0);
        push_pkt(27'd0, 27'd4096, 1'b0, 3'b001);
        push_pkt(27'd4096, 27'd904, 1'b1, 3'b001);
        send_req(27'd0, 27'd5000, 3'b001);
        wait_idle();
        chk("plen0_cnt", {16'd0, ov_pkt_cnt}, 32'd2);
        end_frame();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
